// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm zone arbiter: state encoding, default timing
// values and the zone-index width helper.
package alarm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMING   = 2'b01,
    ARMED    = 2'b10,
    ALERTING = 2'b11
  } state_t;

  localparam int unsigned N_ZONES_DEF     = 4;
  localparam int unsigned ARM_DELAY_DEF   = 31;
  localparam int unsigned SLOT_CYCLES_DEF = 63;

  // Width of a zone index; a single zone still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 32'd1) ? unsigned'($clog2(n)) : 32'd1;
  endfunction

  localparam int unsigned IDX_W_DEF = idx_w(N_ZONES_DEF);

endpackage

// File: rtl/alarm_rr_pick.sv
// Round-robin picker: index of the first set request at or after ptr, wrapping.
// Drives 0 when no request is set.
module alarm_rr_pick
  import alarm_pkg::*;
#(
  parameter int unsigned N_ZONES = N_ZONES_DEF
) (
  input  logic [N_ZONES-1:0]        req,
  input  logic [idx_w(N_ZONES)-1:0] ptr,
  output logic [idx_w(N_ZONES)-1:0] idx
);

  localparam int unsigned IDX_W = idx_w(N_ZONES);

  logic [IDX_W-1:0] cand;
  logic             found;

  // N_ZONES is a power of two, so the index adder wraps modulo N_ZONES on its own
  always_comb begin
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_ZONES; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_zone_arbiter.sv
// Alarm sequencer: arm delay, sticky zone trips, and round-robin arbitration of
// pending zones for one shared alert output with a timed slot per zone.
module alarm_zone_arbiter
  import alarm_pkg::*;
#(
  parameter int unsigned N_ZONES     = N_ZONES_DEF,
  parameter int unsigned ARM_DELAY   = ARM_DELAY_DEF,
  parameter int unsigned SLOT_CYCLES = SLOT_CYCLES_DEF,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      arm_n,
  input  logic                      ack_n,
  input  logic [N_ZONES-1:0]        zone_trip,
  output logic                      armed,
  output logic                      alerting,
  output logic [idx_w(N_ZONES)-1:0] grant,
  output logic [N_ZONES-1:0]        pending,
  output logic [CNT_W-1:0]          timer
);

  localparam int unsigned IDX_W = idx_w(N_ZONES);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   timer_next;
  logic [IDX_W-1:0]   grant_next;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_next;
  logic [IDX_W-1:0]   grant_inc;
  logic [IDX_W-1:0]   pick_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic [N_ZONES-1:0] pending_next;
  logic [N_ZONES-1:0] pend_acc;
  logic [N_ZONES-1:0] pick_req;

  assign grant_inc = grant + IDX_W'(1);

  // Ack clears the granted bit before new trips are merged, so a same-cycle trip wins
  always_comb begin
    pend_acc = pending | zone_trip;
    if (state == ALERTING && !ack_n) begin
      pend_acc = (pending & ~(N_ZONES'(1) << grant)) | zone_trip;
    end
  end

  // First grant uses the registered pending and stored pointer; later grants search after the old grant
  always_comb begin
    pick_req = pending;
    pick_ptr = ptr;
    if (state == ALERTING) begin
      pick_req = pend_acc;
      pick_ptr = grant_inc;
    end
  end

  alarm_rr_pick #(
    .N_ZONES (N_ZONES)
  ) u_pick (
    .req (pick_req),
    .ptr (pick_ptr),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= DISARMED;
      timer   <= '0;
      grant   <= '0;
      pending <= '0;
      ptr     <= '0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      grant   <= grant_next;
      pending <= pending_next;
      ptr     <= ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    timer_next   = timer;
    grant_next   = grant;
    pending_next = pending;
    ptr_next     = ptr;
    case (state)
      DISARMED: begin
        timer_next   = '0;
        grant_next   = '0;
        pending_next = '0;
        if (!arm_n) state_next = ARMING;
      end
      ARMING: begin
        if (!arm_n) begin
          state_next = DISARMED;
          timer_next = '0;
        end else if (timer == CNT_W'(ARM_DELAY)) begin
          state_next = ARMED;
          timer_next = '0;
        end else begin
          timer_next = timer + CNT_W'(1);
        end
      end
      ARMED: begin
        if (!arm_n) begin
          state_next   = DISARMED;
          pending_next = '0;
          grant_next   = '0;
          timer_next   = '0;
        end else begin
          pending_next = pend_acc;
          if (pending != '0) begin
            state_next = ALERTING;
            grant_next = pick_idx;
            timer_next = '0;
          end
        end
      end
      ALERTING: begin
        if (!arm_n) begin
          state_next   = DISARMED;
          pending_next = '0;
          grant_next   = '0;
          timer_next   = '0;
        end else begin
          pending_next = pend_acc;
          if (!ack_n) begin
            ptr_next   = grant_inc;
            timer_next = '0;
            if (pend_acc != '0) begin
              grant_next = pick_idx;
            end else begin
              state_next = ARMED;
              grant_next = '0;
            end
          end else if (timer == CNT_W'(SLOT_CYCLES)) begin
            ptr_next   = grant_inc;
            grant_next = pick_idx;
            timer_next = '0;
          end else begin
            timer_next = timer + CNT_W'(1);
          end
        end
      end
      default: begin
        state_next   = DISARMED;
        timer_next   = '0;
        grant_next   = '0;
        pending_next = '0;
      end
    endcase
  end

  always_comb begin
    armed    = 1'b0;
    alerting = 1'b0;
    case (state)
      ARMED:    armed = 1'b1;
      ALERTING: begin
        armed    = 1'b1;
        alerting = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
